// File: rtl/cmd_sequencer_if.sv
// cmd_sequencer_if: load, run-control and RemoteComm handshake signals of the command sequencer
interface cmd_sequencer_if #(parameter int DEPTH = 16);
  localparam int IW = $clog2(DEPTH);
  logic          load_en;
  logic [IW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [IW:0]   num_cmds;
  logic          start;
  logic          cmd_sent;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic [15:0]   cmd;
  logic          send_cmd;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [IW-1:0] err_idx;
  logic [IW-1:0] cur_idx;
  modport master (output load_en, load_addr, load_data, num_cmds, start, cmd_sent, resp_rdy, resp,
                  input cmd, send_cmd, busy, done, err, err_code, err_idx, cur_idx);
  modport slave (input load_en, load_addr, load_data, num_cmds, start, cmd_sent, resp_rdy, resp,
                 output cmd, send_cmd, busy, done, err, err_code, err_idx, cur_idx);
endinterface

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: replays a loadable table of commands into RemoteComm and checks each acknowledge
module cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 2560000,
  parameter logic [7:0] ACK = 8'hA5
) (
  input logic clk,
  input logic rst,
  cmd_sequencer_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK, DONE, ERR} state_t;
  state_t state, state_n;
  logic [15:0] mem [DEPTH];
  logic [NW-1:0] n_lat;
  logic [CW-1:0] cnt;
  logic [7:0] resp_q;
  logic [1:0] code_n;
  logic sent_q, rdy_q, sent_rise, rdy_rise, go, last, expired;
  assign sent_rise = bus.cmd_sent & ~sent_q;
  assign rdy_rise = bus.resp_rdy & ~rdy_q;
  assign go = bus.start & (state == IDLE || state == DONE || state == ERR);
  assign last = {1'b0, bus.cur_idx} == n_lat - 1'b1;
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign bus.send_cmd = state == SEND;
  assign bus.busy = state inside {LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK};
  assign bus.done = state == DONE;
  assign bus.err = state == ERR;
  always_comb begin
    state_n = state;
    code_n = 2'b00;
    case (state)
      IDLE, DONE, ERR: if (go) state_n = bus.num_cmds == '0 ? DONE : LOAD;
      LOAD: state_n = SEND;
      SEND: state_n = WAIT_SENT;
      WAIT_SENT: begin
        code_n = 2'b01;
        // a response that overtakes cmd_sent also proves the command went out
        state_n = rdy_rise ? CHECK : sent_rise ? WAIT_RESP : expired ? ERR : WAIT_SENT;
      end
      WAIT_RESP: begin
        code_n = 2'b10;
        state_n = rdy_rise ? CHECK : expired ? ERR : WAIT_RESP;
      end
      CHECK: begin
        code_n = 2'b11;
        state_n = resp_q != ACK ? ERR : last ? DONE : LOAD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (state == IDLE && bus.load_en) mem[bus.load_addr] <= bus.load_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.cmd <= '0;
      bus.cur_idx <= '0;
      bus.err_code <= '0;
      bus.err_idx <= '0;
      n_lat <= '0;
      cnt <= '0;
      resp_q <= '0;
      sent_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      sent_q <= bus.cmd_sent;
      rdy_q <= bus.resp_rdy;
      cnt <= state_n != state ? '0 : cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
      if (state == LOAD) bus.cmd <= mem[bus.cur_idx];
      if ((state == WAIT_SENT || state == WAIT_RESP) && rdy_rise) resp_q <= bus.resp;
      if (go) begin
        bus.cur_idx <= '0;
        n_lat <= bus.num_cmds > NW'(DEPTH) ? NW'(DEPTH) : bus.num_cmds;
        bus.err_code <= '0;
      end
      if (state == CHECK && state_n == LOAD) bus.cur_idx <= bus.cur_idx + 1'b1;
      if (state_n == ERR && state != ERR) begin
        bus.err_code <= code_n;
        bus.err_idx <= bus.cur_idx;
      end
    end
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: scenario tasks against a RemoteComm model and a table-level reference of the command script
module tb_cmd_sequencer;
  logic clk, rst;
  cmd_sequencer_if #(.DEPTH(16)) b();
  cmd_sequencer_if #(.DEPTH(16)) bt();
  cmd_sequencer #(.DEPTH(16), .TIMEOUT(1000), .ACK(8'hA5)) u_dut (.clk(clk), .rst(rst), .bus(b));
  cmd_sequencer #(.DEPTH(16), .TIMEOUT(50), .ACK(8'hA5)) u_to (.clk(clk), .rst(rst), .bus(bt));
  int n_cmp = 0, n_fail = 0;
  int n_send = 0, n_resp = 0, n_csent = 0, dbl = 0;
  int rc_bad = -1, rc_same = -1;
  logic [7:0] rc_bad_val = 8'h5A;
  logic [15:0] sent_q[$];
  logic [15:0] ref_tab[16];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b.send_cmd === 1'b1) begin
        n_send++;
        sent_q.push_back(b.cmd);
        if (prev) dbl++;
      end
      prev = b.send_cmd === 1'b1;
    end
  end
  // RemoteComm model: answers every issued command in order
  initial begin
    b.cmd_sent = 1'b0; b.resp_rdy = 1'b0; b.resp = 8'h00;
    forever begin
      @(negedge clk);
      if (n_send > n_resp) begin
        if (n_resp == rc_same) begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          b.resp = 8'hA5; b.cmd_sent = 1'b1; b.resp_rdy = 1'b1;
          @(negedge clk); b.cmd_sent = 1'b0; n_csent++;
          repeat (9) @(negedge clk);
          b.resp_rdy = 1'b0;
        end else begin
          repeat ($urandom_range(20, 100)) @(negedge clk);
          b.cmd_sent = 1'b1;
          @(negedge clk); b.cmd_sent = 1'b0; n_csent++;
          repeat ($urandom_range(20, 100)) @(negedge clk);
          b.resp = (n_resp == rc_bad) ? rc_bad_val : 8'hA5; b.resp_rdy = 1'b1;
          @(negedge clk); b.resp_rdy = 1'b0; b.resp = 8'($urandom);
        end
        n_resp++;
      end
    end
  end
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic load(input int a, input logic [15:0] d);
    b.load_addr = a[3:0]; b.load_data = d; b.load_en = 1'b1;
    @(negedge clk); b.load_en = 1'b0;
  endtask
  task automatic start_run(input int n);
    b.num_cmds = 5'(n); b.start = 1'b1;
    @(negedge clk); b.start = 1'b0;
  endtask
  task automatic wait_end(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30000 && !ok; i++) begin
      @(negedge clk);
      ok = (b.done === 1'b1) || (b.err === 1'b1);
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_end: no done/err within 30000 cycles", nm); end
  endtask
  task automatic test_reset();
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if (b.cmd !== 16'h0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", b.cmd); end
    n_cmp++; if ({b.send_cmd, b.busy, b.done, b.err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {b.send_cmd, b.busy, b.done, b.err}); end
    n_cmp++; if ({b.err_code, b.err_idx, b.cur_idx} !== 10'h0) begin n_fail++; $display("FAIL reset_idx: got %h want 0", {b.err_code, b.err_idx, b.cur_idx}); end
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_script();
    logic [15:0] v[4];
    int base, ns0;
    v = '{16'h0000, 16'h2000, 16'h4002, 16'h23FF};
    for (int i = 0; i < 4; i++) begin load(i, v[i]); ref_tab[i] = v[i]; end
    base = sent_q.size(); ns0 = n_send;
    start_run(4); wait_end("script");
    n_cmp++; if (n_send - ns0 != 4) begin n_fail++; $display("FAIL script_count: got %0d want 4", n_send - ns0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sent_q[base + i] !== ref_tab[i]) begin n_fail++; $display("FAIL script_cmd%0d: got %h want %h", i, sent_q[base + i], ref_tab[i]); end
    end
    n_cmp++; if ({b.done, b.err, b.busy} !== 3'b100) begin n_fail++; $display("FAIL script_status: got %b want 100", {b.done, b.err, b.busy}); end
    n_cmp++; if (dbl != 0) begin n_fail++; $display("FAIL script_pulse: got %0d wide pulses want 0", dbl); end
  endtask
  task automatic test_bad_resp();
    int ns0;
    ns0 = n_send; rc_bad = n_resp + 2; rc_bad_val = 8'h5A;
    start_run(4); wait_end("bad");
    n_cmp++; if ({b.done, b.err} !== 2'b01) begin n_fail++; $display("FAIL bad_status: got %b want 01", {b.done, b.err}); end
    n_cmp++; if (b.err_code !== 2'b11) begin n_fail++; $display("FAIL bad_code: got %b want 11", b.err_code); end
    n_cmp++; if (b.err_idx !== 4'd2) begin n_fail++; $display("FAIL bad_idx: got %0d want 2", b.err_idx); end
    n_cmp++; if (n_send - ns0 != 3) begin n_fail++; $display("FAIL bad_count: got %0d want 3", n_send - ns0); end
    rc_bad = -1;
  endtask
  task automatic test_timeout();
    int t, c;
    do_reset();
    bt.num_cmds = 5'd2; bt.start = 1'b1;
    @(negedge clk); bt.start = 1'b0;
    t = 0; while (bt.send_cmd !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    c = 0; while (bt.err !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    n_cmp++; if (bt.err !== 1'b1 || c > 52) begin n_fail++; $display("FAIL to_sent_time: err=%b after %0d cycles want 1 within 52", bt.err, c); end
    n_cmp++; if ({bt.err_code, bt.err_idx} !== 6'b01_0000) begin n_fail++; $display("FAIL to_sent_code: got %b/%0d want 01/0", bt.err_code, bt.err_idx); end
    bt.start = 1'b1;
    @(negedge clk); bt.start = 1'b0;
    t = 0; while (bt.send_cmd !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    bt.cmd_sent = 1'b1; @(negedge clk); bt.cmd_sent = 1'b0;
    c = 0; while (bt.err !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    n_cmp++; if (bt.err !== 1'b1 || bt.err_code !== 2'b10) begin n_fail++; $display("FAIL to_resp_code: err=%b code=%b want 1/10", bt.err, bt.err_code); end
  endtask
  task automatic test_zero_and_load_lock();
    int ns0, base;
    ns0 = n_send;
    start_run(0);
    n_cmp++; if (b.done !== 1'b1 || n_send != ns0) begin n_fail++; $display("FAIL zero_done: done=%b sends=%0d want 1/0", b.done, n_send - ns0); end
    start_run(4);
    load(1, ~ref_tab[1]);
    wait_end("lock1");
    load(2, ~ref_tab[2]);
    base = sent_q.size();
    start_run(4); wait_end("lock2");
    n_cmp++; if (sent_q.size() - base != 4) begin n_fail++; $display("FAIL lock_count: got %0d want 4", sent_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sent_q[base + i] !== ref_tab[i]) begin n_fail++; $display("FAIL lock_cmd%0d: got %h want %h", i, sent_q[base + i], ref_tab[i]); end
    end
  endtask
  task automatic test_reset_mid();
    int c0, t, base;
    c0 = n_csent;
    start_run(4);
    t = 0; while (n_csent < c0 + 2 && t < 5000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_cmp++; if (b.cur_idx !== 4'd1 || b.busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: idx=%0d busy=%b want 1/1", b.cur_idx, b.busy); end
    #2 rst = 1'b1; #1;
    n_cmp++; if ({b.cmd, b.send_cmd, b.busy, b.done, b.err, b.err_code, b.err_idx, b.cur_idx} !== 30'h0) begin n_fail++; $display("FAIL mid_reset: got %h want 0", {b.cmd, b.send_cmd, b.busy, b.done, b.err, b.err_code, b.err_idx, b.cur_idx}); end
    @(negedge clk); rst = 1'b0;
    t = 0; while (n_resp != n_send && t < 5000) begin @(negedge clk); t++; end
    base = sent_q.size();
    start_run(4); wait_end("mid");
    n_cmp++; if (b.done !== 1'b1 || sent_q.size() - base != 4) begin n_fail++; $display("FAIL mid_rerun: done=%b sends=%0d want 1/4", b.done, sent_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sent_q[base + i] !== ref_tab[i]) begin n_fail++; $display("FAIL mid_cmd%0d: got %h want %h", i, sent_q[base + i], ref_tab[i]); end
    end
  endtask
  task automatic test_same_cycle();
    int ns0, base, t;
    rc_same = n_resp; ns0 = n_send; base = sent_q.size();
    start_run(3);
    t = 0; while (b.resp_rdy !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    n_cmp++; if (n_send - ns0 != 2 || b.cur_idx !== 4'd1 || b.busy !== 1'b1) begin n_fail++; $display("FAIL same_advance: sends=%0d idx=%0d busy=%b want 2/1/1", n_send - ns0, b.cur_idx, b.busy); end
    wait_end("same");
    n_cmp++; if (b.done !== 1'b1 || n_send - ns0 != 3) begin n_fail++; $display("FAIL same_done: done=%b sends=%0d want 1/3", b.done, n_send - ns0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (sent_q[base + i] !== ref_tab[i]) begin n_fail++; $display("FAIL same_cmd%0d: got %h want %h", i, sent_q[base + i], ref_tab[i]); end
    end
    rc_same = -1;
  endtask
  task automatic test_random();
    int n, m, bad, exp_n, base, ns0;
    do_reset();
    for (int i = 0; i < 16; i++) begin ref_tab[i] = 16'($urandom); load(i, ref_tab[i]); end
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 20);
      m = n > 16 ? 16 : n;
      bad = $urandom_range(0, m + 3);
      rc_bad_val = 8'($urandom_range(0, 255));
      if (rc_bad_val == 8'hA5) rc_bad_val = 8'h00;
      rc_bad = bad < m ? n_resp + bad : -1;
      exp_n = bad < m ? bad + 1 : m;
      base = sent_q.size(); ns0 = n_send;
      start_run(n); wait_end("rand");
      n_cmp++; if (n_send - ns0 != exp_n) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d (n=%0d)", r, n_send - ns0, exp_n, n); end
      for (int i = 0; i < exp_n; i++) begin
        n_cmp++; if (sent_q[base + i] !== ref_tab[i]) begin n_fail++; $display("FAIL rand%0d_cmd%0d: got %h want %h", r, i, sent_q[base + i], ref_tab[i]); end
      end
      n_cmp++; if ({b.done, b.err} !== (bad < m ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rand%0d_status: got %b want %b", r, {b.done, b.err}, bad < m ? 2'b01 : 2'b10); end
      if (bad < m) begin
        n_cmp++; if (b.err_code !== 2'b11 || b.err_idx !== 4'(bad)) begin n_fail++; $display("FAIL rand%0d_err: got %b/%0d want 11/%0d", r, b.err_code, b.err_idx, bad); end
      end
    end
    rc_bad = -1;
  endtask
  initial begin
    rst = 1'b0;
    b.load_en = 1'b0; b.load_addr = '0; b.load_data = '0; b.num_cmds = '0; b.start = 1'b0;
    bt.load_en = 1'b0; bt.load_addr = '0; bt.load_data = '0; bt.num_cmds = '0; bt.start = 1'b0;
    bt.cmd_sent = 1'b0; bt.resp_rdy = 1'b0; bt.resp = 8'h00;
    test_reset();
    test_script();
    test_bad_resp();
    test_timeout();
    test_zero_and_load_lock();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
